// File: rtl/mac_psum_accum_multilane.sv
// Multi-lane partial-sum accumulator: adds psums to a bias or a parked running sum,
// parks intermediate sums in an on-chip buffer and emits final sums through an output FIFO.

module mac_psum_accum_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_s;
  logic          pop_s;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    next_ptr = (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
  endfunction

  assign push_s    = push & ~full;
  assign pop_s     = pop & ~empty;
  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign head_data = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge i_clk) begin
    if (push_s) mem_r[wr_ptr_r] <= push_data;
  end
endmodule

module mac_psum_accum_multilane #(
  parameter int LANES      = 4,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 64,
  parameter int BIAS_DEPTH = 4,
  parameter int OUT_DEPTH  = 4,
  parameter bit SAT        = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_bias_enable,
  input  logic                    i_bias_mode,
  input  logic                    i_relu_en,
  input  logic                    i_sat_clr,
  input  logic                    i_psum_valid,
  output logic                    o_psum_ready,
  input  logic [LANES*DATA_W-1:0] i_psum_data,
  input  logic                    i_inter_end,
  input  logic                    i_accum_end,
  input  logic                    i_bias_valid,
  output logic                    o_bias_ready,
  input  logic [LANES*DATA_W-1:0] i_bias_data,
  output logic                    o_output_valid,
  input  logic                    i_output_ready,
  output logic [LANES*DATA_W-1:0] o_output_data,
  output logic                    o_output_end,
  output logic                    o_sat_flag
);
  localparam int LW = LANES * DATA_W;
  localparam logic [DATA_W-1:0] MAX_C = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_C = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [0:0] {PH_FIRST = 1'b0, PH_ACCUM = 1'b1} phase_t;

  // Returns {saturated, sum}
  function automatic logic [DATA_W:0] lane_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W:0] wide_v;
    wide_v = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (SAT && (wide_v[DATA_W] ^ wide_v[DATA_W-1])) begin
      lane_add = {1'b1, (wide_v[DATA_W] ? MIN_C : MAX_C)};
    end else begin
      lane_add = {1'b0, wide_v[DATA_W-1:0]};
    end
  endfunction

  phase_t        phase_r, phase_nxt_s;
  logic [LW-1:0] bias_head_s, buf_head_s, opnd_s, lane_sum_s;
  logic [LW:0]   out_head_s;
  logic          bias_full_s, bias_empty_s, bias_pop_s;
  logic          buf_full_s, buf_empty_s, buf_push_s, buf_pop_s;
  logic          out_full_s, out_empty_s, out_push_s, out_pop_s;
  logic          opnd_valid_s, accept_s, any_sat_s;
  logic          s1_dest_full_s, s1_drain_s, s1_load_s, s0_free_s;
  logic          s0_valid_r, s0_ie_r, s0_ae_r;
  logic [LW-1:0] s0_data_r, s0_opnd_r;
  logic          s1_valid_r, s1_end_r, s1_ae_r;
  logic [LW-1:0] s1_sum_r;
  logic          sat_flag_r;

  // Pipeline flow: stage1 drains when its destination has room, bubbles collapse
  assign s1_dest_full_s = s1_ae_r ? out_full_s : buf_full_s;
  assign s1_drain_s     = s1_valid_r & ~s1_dest_full_s;
  assign s1_load_s      = s0_valid_r & (~s1_valid_r | s1_drain_s);
  assign s0_free_s      = ~s0_valid_r | s1_load_s;
  assign o_psum_ready   = opnd_valid_s & s0_free_s;
  assign accept_s       = i_psum_valid & o_psum_ready;

  assign bias_pop_s = accept_s & (phase_r == PH_FIRST) & i_bias_enable & (i_bias_mode | i_inter_end);
  assign buf_pop_s  = accept_s & (phase_r == PH_ACCUM);
  assign buf_push_s = s1_drain_s & ~s1_ae_r;
  assign out_push_s = s1_drain_s & s1_ae_r;
  assign out_pop_s  = ~out_empty_s & i_output_ready;

  assign o_bias_ready   = ~bias_full_s;
  assign o_output_valid = ~out_empty_s;
  assign o_output_data  = out_head_s[LW-1:0];
  assign o_output_end   = ~out_empty_s & out_head_s[LW];
  assign o_sat_flag     = sat_flag_r;

  mac_psum_accum_fifo #(.W(LW), .DEPTH(BIAS_DEPTH)) u_bias_fifo (
    .i_clk(i_clk), .i_reset(i_reset), .push(i_bias_valid), .push_data(i_bias_data),
    .pop(bias_pop_s), .head_data(bias_head_s), .full(bias_full_s), .empty(bias_empty_s)
  );

  mac_psum_accum_fifo #(.W(LW), .DEPTH(DEPTH)) u_psum_buf (
    .i_clk(i_clk), .i_reset(i_reset), .push(buf_push_s), .push_data(s1_sum_r),
    .pop(buf_pop_s), .head_data(buf_head_s), .full(buf_full_s), .empty(buf_empty_s)
  );

  mac_psum_accum_fifo #(.W(LW + 1), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .i_clk(i_clk), .i_reset(i_reset), .push(out_push_s), .push_data({s1_end_r, s1_sum_r}),
    .pop(out_pop_s), .head_data(out_head_s), .full(out_full_s), .empty(out_empty_s)
  );

  // Operand source: bias (or zero) on the first pass, buffer head afterwards
  always_comb begin
    opnd_valid_s = 1'b0;
    opnd_s       = {LW{1'b0}};
    case (phase_r)
      PH_FIRST: begin
        opnd_valid_s = ~i_bias_enable | ~bias_empty_s;
        opnd_s       = i_bias_enable ? bias_head_s : {LW{1'b0}};
      end
      PH_ACCUM: begin
        opnd_valid_s = ~buf_empty_s;
        opnd_s       = buf_head_s;
      end
      default: begin
        opnd_valid_s = 1'b0;
        opnd_s       = {LW{1'b0}};
      end
    endcase
  end

  // Phase next-state: a pass end selects ACCUM unless it closes the final pass
  always_comb begin
    phase_nxt_s = phase_r;
    if (accept_s && i_inter_end) begin
      case (phase_r)
        PH_FIRST: phase_nxt_s = i_accum_end ? PH_FIRST : PH_ACCUM;
        PH_ACCUM: phase_nxt_s = i_accum_end ? PH_FIRST : PH_ACCUM;
        default:  phase_nxt_s = PH_FIRST;
      endcase
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // Phase register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) phase_r <= PH_FIRST;
    else          phase_r <= phase_nxt_s;
  end

  // Per-lane add; ReLU only touches sums headed for the output
  always_comb begin
    logic [DATA_W:0] res_v;
    res_v      = {(DATA_W+1){1'b0}};
    lane_sum_s = {LW{1'b0}};
    any_sat_s  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      res_v     = lane_add(s0_data_r[k*DATA_W +: DATA_W], s0_opnd_r[k*DATA_W +: DATA_W]);
      any_sat_s = any_sat_s | res_v[DATA_W];
      if (s0_ae_r && i_relu_en && res_v[DATA_W-1]) begin
        lane_sum_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else begin
        lane_sum_s[k*DATA_W +: DATA_W] = res_v[DATA_W-1:0];
      end
    end
  end

  // Stage0: captures the accepted beat together with its operand
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      s0_valid_r <= 1'b0;
      s0_ie_r    <= 1'b0;
      s0_ae_r    <= 1'b0;
      s0_data_r  <= {LW{1'b0}};
      s0_opnd_r  <= {LW{1'b0}};
    end else if (accept_s) begin
      s0_valid_r <= 1'b1;
      s0_ie_r    <= i_inter_end;
      s0_ae_r    <= i_accum_end;
      s0_data_r  <= i_psum_data;
      s0_opnd_r  <= opnd_s;
    end else if (s1_load_s) begin
      s0_valid_r <= 1'b0;
    end
  end

  // Stage1: holds lane sums until the destination FIFO accepts them
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      s1_valid_r <= 1'b0;
      s1_end_r   <= 1'b0;
      s1_ae_r    <= 1'b0;
      s1_sum_r   <= {LW{1'b0}};
    end else if (s1_load_s) begin
      s1_valid_r <= 1'b1;
      s1_end_r   <= s0_ie_r & s0_ae_r;
      s1_ae_r    <= s0_ae_r;
      s1_sum_r   <= lane_sum_s;
    end else if (s1_drain_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Sticky saturation flag; clear wins over a same-cycle set
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                   sat_flag_r <= 1'b0;
    else if (i_sat_clr)             sat_flag_r <= 1'b0;
    else if (s1_load_s & any_sat_s) sat_flag_r <= 1'b1;
  end
endmodule

// File: tb/tb_mac_psum_accum_multilane.sv
// Self-checking bench: directed cases plus randomized jobs checked against a
// job-level arithmetic model, run on a saturating and a wrapping instance in lockstep.

module tb_mac_psum_accum_multilane;
  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int LW    = LANES * DW;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam int TMO = 2000;

  typedef logic [LW:0] cmp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic bias_enable, bias_mode, relu_en, sat_clr;
  logic psum_valid, inter_end, accum_end, bias_valid, output_ready;
  logic [LW-1:0] psum_data, bias_data;
  logic psum_ready, bias_ready, out_valid, out_end, sat_flag;
  logic psum_ready_w, bias_ready_w, out_valid_w, out_end_w, sat_flag_w;
  logic [LW-1:0] out_data, out_data_w;

  int n_checks = 0;
  int n_fail   = 0;

  logic [LW+1:0] beat_q[$];
  logic [LW-1:0] bias_q[$];
  cmp_t          exp_q[$];
  cmp_t          expw_q[$];
  bit            model_sat;

  always #5 clk = ~clk;

  mac_psum_accum_multilane #(.LANES(LANES), .DATA_W(DW), .DEPTH(64), .BIAS_DEPTH(4), .OUT_DEPTH(4), .SAT(1'b1)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_bias_enable(bias_enable), .i_bias_mode(bias_mode),
    .i_relu_en(relu_en), .i_sat_clr(sat_clr), .i_psum_valid(psum_valid), .o_psum_ready(psum_ready),
    .i_psum_data(psum_data), .i_inter_end(inter_end), .i_accum_end(accum_end),
    .i_bias_valid(bias_valid), .o_bias_ready(bias_ready), .i_bias_data(bias_data),
    .o_output_valid(out_valid), .i_output_ready(output_ready), .o_output_data(out_data),
    .o_output_end(out_end), .o_sat_flag(sat_flag)
  );

  mac_psum_accum_multilane #(.LANES(LANES), .DATA_W(DW), .DEPTH(64), .BIAS_DEPTH(4), .OUT_DEPTH(4), .SAT(1'b0)) dut_w (
    .i_clk(clk), .i_reset(rst_n), .i_bias_enable(bias_enable), .i_bias_mode(bias_mode),
    .i_relu_en(relu_en), .i_sat_clr(sat_clr), .i_psum_valid(psum_valid), .o_psum_ready(psum_ready_w),
    .i_psum_data(psum_data), .i_inter_end(inter_end), .i_accum_end(accum_end),
    .i_bias_valid(bias_valid), .o_bias_ready(bias_ready_w), .i_bias_data(bias_data),
    .o_output_valid(out_valid_w), .i_output_ready(output_ready), .o_output_data(out_data_w),
    .o_output_end(out_end_w), .o_sat_flag(sat_flag_w)
  );

  task automatic check_eq(input string tag, input cmp_t got, input cmp_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    pack4 = {a3, a2, a1, a0};
  endfunction

  function automatic logic [LW-1:0] rand_word(input int kind);
    logic [LW-1:0] w;
    int s;
    w = '0;
    for (int l = 0; l < LANES; l++) begin
      s = (kind == 0) ? (int'($urandom_range(0, 200)) - 100) : int'($urandom());
      w[l*DW +: DW] = s;
    end
    return w;
  endfunction

  // All handshake tasks start and end on a falling edge
  task automatic push_beat(input logic [LW-1:0] d, input bit ie, input bit ae, output bit ok);
    psum_valid = 1'b1; psum_data = d; inter_end = ie; accum_end = ae;
    ok = 1'b0;
    for (int t = 0; t < TMO && !ok; t++) begin
      #1;
      ok = psum_ready;
      @(posedge clk);
      @(negedge clk);
    end
    psum_valid = 1'b0;
  endtask

  task automatic push_bias(input logic [LW-1:0] d, output bit ok);
    bias_valid = 1'b1; bias_data = d;
    ok = 1'b0;
    for (int t = 0; t < TMO && !ok; t++) begin
      #1;
      ok = bias_ready;
      @(posedge clk);
      @(negedge clk);
    end
    bias_valid = 1'b0;
  endtask

  task automatic pop_out(output cmp_t v, output cmp_t vw, output bit ok);
    ok = 1'b0; v = '0; vw = '0;
    output_ready = 1'b1;
    for (int t = 0; t < TMO && !ok; t++) begin
      #1;
      if (out_valid) begin
        ok = 1'b1;
        v  = {out_end, out_data};
        vw = {out_end_w, out_data_w};
      end
      @(posedge clk);
      @(negedge clk);
    end
    output_ready = 1'b0;
  endtask

  // Job model: per-beat running sums in plain integer arithmetic
  task automatic gen_job(input int nb, input int np, input int kind);
    longint acc_s [8][LANES];
    int     acc_w [8][LANES];
    logic [LW-1:0] word, data, es, ew;
    longint v;
    word = '0;
    if (bias_enable && !bias_mode) begin word = rand_word(kind); bias_q.push_back(word); end
    for (int b = 0; b < nb; b++) begin
      if (bias_enable && bias_mode) begin word = rand_word(kind); bias_q.push_back(word); end
      for (int l = 0; l < LANES; l++) begin
        v = bias_enable ? longint'($signed(word[l*DW +: DW])) : 64'sd0;
        acc_s[b][l] = v;
        acc_w[b][l] = int'(v);
      end
    end
    for (int p = 0; p < np; p++) begin
      for (int b = 0; b < nb; b++) begin
        data = rand_word(kind);
        beat_q.push_back({(p == np - 1), (b == nb - 1), data});
        for (int l = 0; l < LANES; l++) begin
          v = longint'($signed(data[l*DW +: DW]));
          acc_s[b][l] = acc_s[b][l] + v;
          if (acc_s[b][l] > SMAX) begin acc_s[b][l] = SMAX; model_sat = 1'b1; end
          else if (acc_s[b][l] < SMIN) begin acc_s[b][l] = SMIN; model_sat = 1'b1; end
          acc_w[b][l] = int'(longint'(acc_w[b][l]) + v);
        end
      end
    end
    for (int b = 0; b < nb; b++) begin
      for (int l = 0; l < LANES; l++) begin
        es[l*DW +: DW] = (relu_en && acc_s[b][l] < 0) ? 32'd0 : DW'(acc_s[b][l]);
        ew[l*DW +: DW] = (relu_en && acc_w[b][l] < 0) ? 32'd0 : DW'(acc_w[b][l]);
      end
      exp_q.push_back({(b == nb - 1), es});
      expw_q.push_back({(b == nb - 1), ew});
    end
  endtask

  task automatic drive_beats();
    bit ok;
    logic [LW+1:0] bt;
    while (beat_q.size() > 0) begin
      bt = beat_q.pop_front();
      repeat ($urandom_range(0, 1)) @(negedge clk);
      push_beat(bt[LW-1:0], bt[LW], bt[LW+1], ok);
      check_eq("beat_accept", cmp_t'(ok), cmp_t'(1));
      if (!ok) beat_q.delete();
    end
  endtask

  task automatic feed_bias();
    bit ok;
    while (bias_q.size() > 0) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push_bias(bias_q.pop_front(), ok);
      check_eq("bias_accept", cmp_t'(ok), cmp_t'(1));
      if (!ok) bias_q.delete();
    end
  endtask

  task automatic monitor(input int n, input int bp);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 20000) begin
      case (bp)
        0:       output_ready = 1'b1;
        1:       output_ready = 1'($urandom_range(0, 1));
        default: output_ready = ((cyc % 16) >= 10);
      endcase
      #1;
      if (out_valid && output_ready) begin
        check_eq("out_sat", {out_end, out_data}, exp_q.pop_front());
        check_eq("out_wrap", {out_end_w, out_data_w}, expw_q.pop_front());
        got++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    output_ready = 1'b0;
    check_eq("out_count", cmp_t'(got), cmp_t'(n));
  endtask

  task automatic run_scenario(input bit en, input bit mode, input bit relu, input int kind, input int bp, input bit single);
    int n;
    bias_enable = en; bias_mode = mode; relu_en = relu;
    sat_clr = 1'b1; @(negedge clk); sat_clr = 1'b0;
    model_sat = 1'b0;
    for (int j = 0; j < 5; j++) begin
      gen_job(single ? 1 : int'($urandom_range(1, 6)), single ? 4 : int'($urandom_range(1, 4)), kind);
    end
    n = exp_q.size();
    fork
      drive_beats();
      feed_bias();
      monitor(n, bp);
    join
    check_eq("sat_flag", cmp_t'(sat_flag), cmp_t'(model_sat));
    check_eq("sat_flag_wrap", cmp_t'(sat_flag_w), cmp_t'(0));
    exp_q.delete(); expw_q.delete();
  endtask

  initial begin
    bit ok;
    cmp_t v, vw;
    rst_n = 1'b0; bias_enable = 1'b1; bias_mode = 1'b0; relu_en = 1'b0; sat_clr = 1'b0;
    psum_valid = 1'b0; inter_end = 1'b0; accum_end = 1'b0; bias_valid = 1'b0;
    output_ready = 1'b0; psum_data = '0; bias_data = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", cmp_t'(out_valid), cmp_t'(0));
    check_eq("rst_out_end", cmp_t'(out_end), cmp_t'(0));
    check_eq("rst_sat_flag", cmp_t'(sat_flag), cmp_t'(0));
    check_eq("rst_bias_ready", cmp_t'(bias_ready), cmp_t'(1));
    check_eq("rst_psum_ready", cmp_t'(psum_ready), cmp_t'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single pass, 3 beats of ones on bias {10,20,30,40}, latency C+3
    push_bias(pack4(10, 20, 30, 40), ok);
    push_beat(pack4(1, 1, 1, 1), 1'b0, 1'b1, ok);
    check_eq("lat_c1", cmp_t'(out_valid), cmp_t'(0));
    @(posedge clk); #1;
    check_eq("lat_c2", cmp_t'(out_valid), cmp_t'(0));
    @(posedge clk); #1;
    check_eq("lat_c3", cmp_t'(out_valid), cmp_t'(1));
    @(negedge clk);
    push_beat(pack4(1, 1, 1, 1), 1'b0, 1'b1, ok);
    push_beat(pack4(1, 1, 1, 1), 1'b1, 1'b1, ok);
    for (int i = 0; i < 3; i++) begin
      pop_out(v, vw, ok);
      check_eq("single_pass", v, {(i == 2), pack4(11, 21, 31, 41)});
    end

    // Three passes of 2-beat groups, one bias word consumed
    push_bias(pack4(100, 0, 0, 0), ok);
    push_bias(pack4(50, 0, 0, 0), ok);
    push_beat(pack4(5, 0, 0, 0), 1'b0, 1'b0, ok);
    push_beat(pack4(7, 0, 0, 0), 1'b1, 1'b0, ok);
    push_beat(pack4(1, 0, 0, 0), 1'b0, 1'b0, ok);
    push_beat(pack4(1, 0, 0, 0), 1'b1, 1'b0, ok);
    push_beat(pack4(2, 0, 0, 0), 1'b0, 1'b1, ok);
    push_beat(pack4(3, 0, 0, 0), 1'b1, 1'b1, ok);
    pop_out(v, vw, ok);
    check_eq("multipass_0", v, {1'b0, pack4(108, 0, 0, 0)});
    pop_out(v, vw, ok);
    check_eq("multipass_1", v, {1'b1, pack4(111, 0, 0, 0)});
    push_beat(pack4(1, 0, 0, 0), 1'b1, 1'b1, ok);
    pop_out(v, vw, ok);
    check_eq("second_bias", v, {1'b1, pack4(51, 0, 0, 0)});

    // Saturation versus wrap, sticky flag and clear
    push_bias(pack4(32'h7FFFFFF0, 0, -3, 0), ok);
    push_beat(pack4(32'h20, 0, 4, 0), 1'b1, 1'b1, ok);
    pop_out(v, vw, ok);
    check_eq("sat_value", v, {1'b1, pack4(32'h7FFFFFFF, 0, 1, 0)});
    check_eq("wrap_value", vw, {1'b1, pack4(32'h80000010, 0, 1, 0)});
    check_eq("sat_flag_set", cmp_t'(sat_flag), cmp_t'(1));
    check_eq("wrap_flag_clear", cmp_t'(sat_flag_w), cmp_t'(0));
    sat_clr = 1'b1; @(negedge clk); sat_clr = 1'b0;
    check_eq("sat_flag_cleared", cmp_t'(sat_flag), cmp_t'(0));

    // ReLU on final sums only; intermediate negatives kept
    relu_en = 1'b1; bias_enable = 1'b0;
    push_beat(pack4(-5, 7, 0, -1), 1'b1, 1'b1, ok);
    pop_out(v, vw, ok);
    check_eq("relu_single", v, {1'b1, pack4(0, 7, 0, 0)});
    push_beat(pack4(-5, -5, 3, 0), 1'b1, 1'b0, ok);
    push_beat(pack4(8, 2, -4, 0), 1'b1, 1'b1, ok);
    pop_out(v, vw, ok);
    check_eq("relu_two_pass", v, {1'b1, pack4(3, 0, 0, 0)});
    relu_en = 1'b0; bias_enable = 1'b1;

    // Asynchronous reset with data in flight
    push_bias(pack4(1, 2, 3, 4), ok);
    push_beat(pack4(1, 1, 1, 1), 1'b0, 1'b1, ok);
    push_beat(pack4(2, 2, 2, 2), 1'b0, 1'b1, ok);
    repeat (4) @(negedge clk);
    check_eq("pre_rst_valid", cmp_t'(out_valid), cmp_t'(1));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", cmp_t'(out_valid), cmp_t'(0));
    check_eq("mid_rst_end", cmp_t'(out_end), cmp_t'(0));
    check_eq("mid_rst_psum_ready", cmp_t'(psum_ready), cmp_t'(0));
    check_eq("mid_rst_bias_ready", cmp_t'(bias_ready), cmp_t'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized jobs: en, mode, relu, kind, backpressure, single-beat groups
    run_scenario(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    run_scenario(1'b1, 1'b1, 1'b1, 1, 1, 1'b0);
    run_scenario(1'b0, 1'b1, 1'b0, 0, 1, 1'b1);
    run_scenario(1'b1, 1'b0, 1'b1, 1, 2, 1'b0);
    run_scenario(1'b1, 1'b1, 1'b0, 0, 2, 1'b1);
    run_scenario(1'b1, 1'b1, 1'b0, 1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
